// File: rtl/fg_pkg.sv
// Shared definitions for the function generator parameter path.
// Contents:
//   PARAM_W        - width of the 78-bit parameter bundle
//   *_LSB / *_W    - field offsets and widths inside the bundle
//                    {wave, freqSet, freqDesired, duty, min, max}
//   DUTY_MAX       - largest legal duty value (percent)
//   CH_A / CH_B    - channel select encodings
//   arb_state_e    - load_arbiter FSM states
//   field_*()      - bundle field extractors
package fg_pkg;

  localparam int PARAM_W  = 78;

  localparam int MAX_LSB  = 0;
  localparam int MAX_W    = 12;
  localparam int MIN_LSB  = 12;
  localparam int MIN_W    = 12;
  localparam int DUTY_LSB = 24;
  localparam int DUTY_W   = 7;
  localparam int FDES_LSB = 31;
  localparam int FDES_W   = 17;
  localparam int FSET_LSB = 48;
  localparam int FSET_W   = 28;
  localparam int WAVE_LSB = 76;
  localparam int WAVE_W   = 2;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd100;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } arb_state_e;

  function automatic logic [MAX_W-1:0] field_max(input logic [PARAM_W-1:0] p);
    return p[MAX_LSB +: MAX_W];
  endfunction

  function automatic logic [MIN_W-1:0] field_min(input logic [PARAM_W-1:0] p);
    return p[MIN_LSB +: MIN_W];
  endfunction

  function automatic logic [DUTY_W-1:0] field_duty(input logic [PARAM_W-1:0] p);
    return p[DUTY_LSB +: DUTY_W];
  endfunction

endpackage

// File: rtl/param_check.sv
// Combinational sanity check of a parameter bundle before it may reach the
// channel latches. Only instantiated when PARAM_CHECK_EN is defined.
// Ports:
//   par_i  in  PARAM_W  candidate bundle
//   valid  out 1        high when min <= max (unsigned) and duty <= DUTY_MAX
module param_check
  import fg_pkg::*;
(
  input  logic [PARAM_W-1:0] par_i,
  output logic               valid
);

  // Frequency and waveform fields have no legality constraint here.
  logic unused_fields;
  assign unused_fields = ^par_i[PARAM_W-1:DUTY_LSB+DUTY_W];

  assign valid = (field_min(par_i) <= field_max(par_i)) &&
                 (field_duty(par_i) <= DUTY_MAX);

endmodule

// File: rtl/load_arbiter.sv
// Arbitrates parameter writes from the front-panel UI and the sweep engine
// onto the shared channel parameter bus. A grant produces a one-cycle load
// strobe for channel A or B with the chosen bundle held on par_out.
// Optional feature macro: PARAM_CHECK_EN (bundle legality check; illegal
// bundles are answered with nak and never loaded). Without it every bundle
// is accepted and nak outputs stay 0.
// Parameters:
//   HOLDOFF  idle cycles after each grant before re-arbitration (>= 0)
// Ports:
//   clk_4hz, reset            parameter clock, synchronous active-high reset
//   req_ui/ch_ui/par_ui       UI request level, target channel, bundle
//   ack_ui/nak_ui             one-cycle accept / reject pulses to the UI
//   req_swp/ch_swp/par_swp    sweep engine request set
//   ack_swp/nak_swp           one-cycle accept / reject pulses to the sweep
//   par_out                   registered bundle to the channel latches
//   load_A/load_B             one-cycle load strobes
//   busy                      high whenever the FSM is not IDLE
//   grant_id                  requester of the last grant (0 UI, 1 sweep)
module load_arbiter
  import fg_pkg::*;
#(
  parameter int HOLDOFF = 2
) (
  input  logic               clk_4hz,
  input  logic               reset,
  input  logic               req_ui,
  input  logic               ch_ui,
  input  logic [PARAM_W-1:0] par_ui,
  output logic               ack_ui,
  output logic               nak_ui,
  input  logic               req_swp,
  input  logic               ch_swp,
  input  logic [PARAM_W-1:0] par_swp,
  output logic               ack_swp,
  output logic               nak_swp,
  output logic [PARAM_W-1:0] par_out,
  output logic               load_A,
  output logic               load_B,
  output logic               busy,
  output logic               grant_id
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PARAM_W-1:0] par_q, par_d;
  logic               gid_q, gid_d;
  logic               load_a_q, load_a_d;
  logic               load_b_q, load_b_d;
  logic               ack_ui_q, ack_ui_d;
  logic               ack_swp_q, ack_swp_d;
  logic               nak_ui_q, nak_ui_d;
  logic               nak_swp_q, nak_swp_d;
  logic               busy_q, busy_d;

  logic               win_swp_s;
  logic               sel_ch_s;
  logic [PARAM_W-1:0] sel_par_s;
  logic               valid_s;

  // On a tie the winner is the requester that did not get the last grant.
  assign win_swp_s = req_swp && (!req_ui || !gid_q);
  assign sel_ch_s  = win_swp_s ? ch_swp  : ch_ui;
  assign sel_par_s = win_swp_s ? par_swp : par_ui;

`ifdef PARAM_CHECK_EN
  param_check u_param_check (
    .par_i (sel_par_s),
    .valid (valid_s)
  );
`else
  assign valid_s = 1'b1;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    gid_d     = gid_q;
    load_a_d  = 1'b0;
    load_b_d  = 1'b0;
    ack_ui_d  = 1'b0;
    ack_swp_d = 1'b0;
    nak_ui_d  = 1'b0;
    nak_swp_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_ui || req_swp) begin
          gid_d = win_swp_s;
          cnt_d = '0;
          if (valid_s) begin
            par_d     = sel_par_s;
            ack_ui_d  = !win_swp_s;
            ack_swp_d = win_swp_s;
            load_a_d  = (sel_ch_s == CH_A);
            load_b_d  = (sel_ch_s == CH_B);
            state_d   = COMMIT;
          end else begin
            nak_ui_d  = !win_swp_s;
            nak_swp_d = win_swp_s;
            if (HOLDOFF == 0) begin
              state_d = IDLE;
            end else begin
              state_d = HOLD;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        cnt_d = '0;
        if (HOLDOFF == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Requests are ignored here; they are not queued.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = HOLD;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_4hz) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      par_q     <= '0;
      gid_q     <= 1'b1;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      ack_ui_q  <= 1'b0;
      ack_swp_q <= 1'b0;
      nak_ui_q  <= 1'b0;
      nak_swp_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      gid_q     <= gid_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      ack_ui_q  <= ack_ui_d;
      ack_swp_q <= ack_swp_d;
      nak_ui_q  <= nak_ui_d;
      nak_swp_q <= nak_swp_d;
      busy_q    <= busy_d;
    end
  end

  assign par_out  = par_q;
  assign load_A   = load_a_q;
  assign load_B   = load_b_q;
  assign ack_ui   = ack_ui_q;
  assign ack_swp  = ack_swp_q;
  assign nak_ui   = nak_ui_q;
  assign nak_swp  = nak_swp_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_load_arbiter.sv
// Directed testbench for load_arbiter (HOLDOFF = 2). Works in both the
// default build and with PARAM_CHECK_EN defined.
// Status vector layout compared on each step:
//   {load_A, load_B, ack_ui, nak_ui, ack_swp, nak_swp, busy, grant_id}
module tb_load_arbiter;
  import fg_pkg::*;

  logic               clk_4hz = 1'b0;
  logic               reset   = 1'b1;
  logic               req_ui  = 1'b0;
  logic               ch_ui   = 1'b0;
  logic [PARAM_W-1:0] par_ui  = '0;
  logic               req_swp = 1'b0;
  logic               ch_swp  = 1'b0;
  logic [PARAM_W-1:0] par_swp = '0;
  logic               ack_ui, nak_ui, ack_swp, nak_swp;
  logic [PARAM_W-1:0] par_out;
  logic               load_A, load_B, busy, grant_id;

  int n_cmp = 0;
  int n_err = 0;

  load_arbiter #(.HOLDOFF(2)) dut (
    .clk_4hz  (clk_4hz),
    .reset    (reset),
    .req_ui   (req_ui),
    .ch_ui    (ch_ui),
    .par_ui   (par_ui),
    .ack_ui   (ack_ui),
    .nak_ui   (nak_ui),
    .req_swp  (req_swp),
    .ch_swp   (ch_swp),
    .par_swp  (par_swp),
    .ack_swp  (ack_swp),
    .nak_swp  (nak_swp),
    .par_out  (par_out),
    .load_A   (load_A),
    .load_B   (load_B),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk_4hz = ~clk_4hz;

  function automatic logic [PARAM_W-1:0] mk(input logic [1:0] wave, input logic [27:0] fset,
                                            input logic [16:0] fdes, input logic [6:0] duty,
                                            input logic [11:0] mn, input logic [11:0] mx);
    return {wave, fset, fdes, duty, mn, mx};
  endfunction

  function automatic logic [7:0] status();
    return {load_A, load_B, ack_ui, nak_ui, ack_swp, nak_swp, busy, grant_id};
  endfunction

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk_4hz);
    #1;
  endtask

  logic [PARAM_W-1:0] p_single, p_ui, p_swp, p_hold, p_bad, p_duty101, p_duty100;

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++;
    if (status() !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_status: got %b want %b", status(), 8'b0000_0001);
    end
    n_cmp++;
    if (par_out !== '0) begin
      n_err++;
      $display("FAIL reset_par: got %h want 0", par_out);
    end
  endtask

  task automatic test_single_ui();
    logic [7:0] exp [4];
    exp = '{8'b0110_0010, 8'b0000_0010, 8'b0000_0010, 8'b0000_0000};
    par_ui = p_single;
    ch_ui  = CH_B;
    req_ui = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      req_ui = 1'b0;
      n_cmp++;
      if (status() !== exp[i]) begin
        n_err++;
        $display("FAIL single_ui_status[%0d]: got %b want %b", i, status(), exp[i]);
      end
      n_cmp++;
      if (par_out !== p_single) begin
        n_err++;
        $display("FAIL single_ui_par[%0d]: got %h want %h", i, par_out, p_single);
      end
    end
  endtask

  task automatic test_round_robin();
    logic       swp_turn;
    logic [7:0] exp;
    par_ui  = p_ui;
    ch_ui   = CH_A;
    par_swp = p_swp;
    ch_swp  = CH_B;
    req_ui  = 1'b1;
    req_swp = 1'b1;
    swp_turn = 1'b1;  // last grant went to UI
    for (int g = 0; g < 4; g++) begin
      step();
      exp = swp_turn ? 8'b0100_1011 : 8'b1010_0010;
      n_cmp++;
      if (status() !== exp) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got %b want %b", g, status(), exp);
      end
      n_cmp++;
      if (par_out !== (swp_turn ? p_swp : p_ui)) begin
        n_err++;
        $display("FAIL rr_par[%0d]: got %h want %h", g, par_out, swp_turn ? p_swp : p_ui);
      end
      for (int c = 0; c < 3; c++) begin
        step();
        exp = {6'b0, (c < 2), swp_turn};
        n_cmp++;
        if (status() !== exp) begin
          n_err++;
          $display("FAIL rr_gap[%0d.%0d]: got %b want %b", g, c, status(), exp);
        end
      end
      swp_turn = ~swp_turn;
    end
    req_ui  = 1'b0;
    req_swp = 1'b0;
  endtask

  task automatic test_hold_window();
    logic [7:0] exp [6];
    exp = '{8'b1010_0010, 8'b0000_0010, 8'b0000_0010,
            8'b0000_0000, 8'b0000_0000, 8'b0000_0000};
    par_ui  = p_hold;
    ch_ui   = CH_A;
    par_swp = p_swp;
    req_ui  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      req_ui  = 1'b0;
      req_swp = (i == 1);  // arrives during HOLD, gone before IDLE
      n_cmp++;
      if (status() !== exp[i]) begin
        n_err++;
        $display("FAIL hold_status[%0d]: got %b want %b", i, status(), exp[i]);
      end
    end
    n_cmp++;
    if (par_out !== p_hold) begin
      n_err++;
      $display("FAIL hold_par: got %h want %h", par_out, p_hold);
    end
  endtask

`ifdef PARAM_CHECK_EN
  task automatic test_reject();
    logic [PARAM_W-1:0] bundles [3];
    bundles = '{p_bad, p_duty101, p_duty100};
    ch_ui = CH_B;
    for (int b = 0; b < 2; b++) begin
      par_ui = bundles[b];
      req_ui = 1'b1;
      step();
      req_ui = 1'b0;
      n_cmp++;
      if (status() !== 8'b0001_0010) begin
        n_err++;
        $display("FAIL reject_nak[%0d]: got %b want %b", b, status(), 8'b0001_0010);
      end
      n_cmp++;
      if (par_out !== p_hold) begin
        n_err++;
        $display("FAIL reject_par[%0d]: got %h want %h", b, par_out, p_hold);
      end
      step();
      step();
      n_cmp++;
      if (status() !== 8'b0000_0000) begin
        n_err++;
        $display("FAIL reject_idle[%0d]: got %b want %b", b, status(), 8'b0000_0000);
      end
    end
    par_ui = bundles[2];
    req_ui = 1'b1;
    step();
    req_ui = 1'b0;
    n_cmp++;
    if (status() !== 8'b0110_0010 || par_out !== p_duty100) begin
      n_err++;
      $display("FAIL duty100_ack: got %b/%h want %b/%h", status(), par_out, 8'b0110_0010, p_duty100);
    end
    for (int c = 0; c < 3; c++) step();
  endtask
`else
  task automatic test_no_check();
    par_ui = p_bad;
    ch_ui  = CH_B;
    req_ui = 1'b1;
    step();
    req_ui = 1'b0;
    n_cmp++;
    if (status() !== 8'b0110_0010) begin
      n_err++;
      $display("FAIL nocheck_ack: got %b want %b", status(), 8'b0110_0010);
    end
    n_cmp++;
    if (par_out !== p_bad) begin
      n_err++;
      $display("FAIL nocheck_par: got %h want %h", par_out, p_bad);
    end
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (status() !== 8'b0000_0000) begin
      n_err++;
      $display("FAIL nocheck_idle: got %b want %b", status(), 8'b0000_0000);
    end
  endtask
`endif

  task automatic test_reset_in_commit();
    par_ui  = p_ui;
    ch_ui   = CH_A;
    par_swp = p_swp;
    ch_swp  = CH_B;
    req_ui  = 1'b1;
    req_swp = 1'b1;
    step();
    n_cmp++;
    if (status() !== 8'b0100_1011) begin
      n_err++;
      $display("FAIL rst_commit_grant: got %b want %b", status(), 8'b0100_1011);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (status() !== 8'b0000_0001 || par_out !== '0) begin
      n_err++;
      $display("FAIL rst_commit_clear: got %b/%h want %b/0", status(), par_out, 8'b0000_0001);
    end
    step();
    req_ui  = 1'b0;
    req_swp = 1'b0;
    n_cmp++;
    if (status() !== 8'b1010_0010 || par_out !== p_ui) begin
      n_err++;
      $display("FAIL rst_first_tie: got %b/%h want %b/%h", status(), par_out, 8'b1010_0010, p_ui);
    end
    for (int c = 0; c < 3; c++) step();
  endtask

  initial begin
    p_single  = mk(2'd0, 28'd0, 17'd0, 7'd50, 12'h100, 12'hC00);
    p_ui      = mk(2'd1, 28'h0ABCDEF, 17'h1F00F, 7'd25, 12'h010, 12'h3FF);
    p_swp     = mk(2'd2, 28'h1234567, 17'h00A5A, 7'd75, 12'h200, 12'hE00);
    p_hold    = mk(2'd3, 28'h0000100, 17'h00123, 7'd10, 12'h000, 12'hFFF);
    p_bad     = mk(2'd0, 28'h0000200, 17'h00200, 7'd50, 12'h800, 12'h400);
    p_duty101 = mk(2'd1, 28'h0000300, 17'h00300, 7'd101, 12'h100, 12'h200);
    p_duty100 = mk(2'd2, 28'h0000400, 17'h00400, 7'd100, 12'h100, 12'h200);

    test_reset();
    test_single_ui();
    test_round_robin();
    test_hold_window();
`ifdef PARAM_CHECK_EN
    test_reject();
`else
    test_no_check();
`endif
    test_reset_in_commit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_arbiter.md
# load_arbiter

Arbitrates writes into the function generator's per-channel parameter registers. Two requesters share one parameter bus: the front-panel UI and the automatic sweep engine. A granted request produces a single-cycle load strobe to the channel A or channel B register bank, with the chosen parameter bundle held stable on a registered bus. The block sits between the UI/sweep logic and the channel parameter latches, and replaces the ad-hoc `data_x && load` gating.

## Interface
- `HOLDOFF`, default 2: idle cycles after each grant before the next arbitration (≥0).
- `clk_4hz`  in  1  system parameter clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_ui`  in  1  UI request; level, held until `ack_ui` or `nak_ui`.
- `ch_ui`  in  1  UI target channel (0 = A, 1 = B).
- `par_ui`  in  78  UI parameter bundle {wave[1:0], freqSet[27:0], freqDesired[16:0], duty[6:0], min[11:0], max[11:0]} (MSB→LSB).
- `ack_ui` / `nak_ui`  out  1  one-cycle accept / reject pulses to UI.
- `req_swp`, `ch_swp`, `par_swp`, `ack_swp`, `nak_swp`: same as the UI set, for the sweep engine.
- `par_out`  out  78  registered bundle to the channel latches.
- `load_A` / `load_B`  out  1  one-cycle load strobes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  1  requester of the last grant (0 = UI, 1 = sweep).

## Operation
- FSM states: IDLE, COMMIT, HOLD.
- **IDLE, no request:** stay in IDLE.
- **IDLE, request present:** select a requester:
  - Only one `req` high: that requester wins.
  - Both high: round-robin. The winner is the requester ≠ `grant_id`.
  - `grant_id` is updated on every grant, whether accepted or rejected.
- **Selected bundle valid:**
  - `par_out` ← selected bundle.
  - `ack_x` ← 1 for the winner.
  - `load_A` or `load_B` ← 1 per the selected channel.
  - Next state COMMIT.
- **Selected bundle invalid** (only when the check is compiled in):
  - `nak_x` ← 1 for the winner.
  - `par_out` unchanged, no load strobe.
  - Next state HOLD, or IDLE when `HOLDOFF` = 0.
- **COMMIT:** clear strobes and ack. Next state HOLD, or IDLE when `HOLDOFF` = 0.
- **HOLD:** counter counts `HOLDOFF` cycles, then IDLE. Requests are ignored, not queued.
- **Request dropped before grant:** ignored; no ack and no nak.
- **Requester protocol:** a requester must deassert `req` on the edge after seeing ack/nak. A `req` still high when the FSM re-enters IDLE counts as a new request.
- **Strobes:** `load_A` and `load_B` are never high together. At most one ack/nak pulse occurs per grant.
- **Reset values, applied at any point including mid-COMMIT:**
  - state IDLE, hold counter 0.
  - `par_out` = 0.
  - all strobes, acks and naks 0.
  - `busy` 0.
  - `grant_id` = 1, so the UI wins the first tie.

## Timing
- Grant edge k: IDLE with a request. Outputs (`par_out`, `load_x`, `ack_x`) are high during cycle k→k+1 only.
- Edge k+1: COMMIT → HOLD.
- IDLE is re-entered at edge k+1+`HOLDOFF`. The earliest next grant is edge k+2+`HOLDOFF`, i.e. 4 cycles (1 s) at the default.
- Reject path: nak at edge k, IDLE at edge k+`HOLDOFF`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PARAM_CHECK_EN` defined:
  - A bundle is valid iff min ≤ max (unsigned 12-bit) and duty ≤ 100.
  - Invalid bundles are naked and never reach the latches.
- Undefined:
  - Every bundle is accepted; the nak outputs are tied 0.
  - The checker is not instantiated.

## Structure
- Shared package `fg_pkg`:
  - `PARAM_W` = 78.
  - Field LSB offsets and widths (MAX 0/12, MIN 12/12, DUTY 24/7, FDES 31/17, FSET 48/28, WAVE 76/2).
  - `DUTY_MAX` = 100.
  - FSM state enum.
  - Channel constants `CH_A` = 0, `CH_B` = 1.
- Sub-module `param_check`: combinational; takes the 78-bit bundle and outputs `valid`. Instantiated only under `PARAM_CHECK_EN`.

## Test plan
- **Single UI request:** after reset, `req_ui`=1, `ch_ui`=1, max=0xC00, min=0x100, duty=50 → next cycle `load_B`=1, `ack_ui`=1 for one cycle, `par_out` = bundle, `load_A`=0, `grant_id`=0.
- **Round-robin:** `req_ui` and `req_swp` held high (requesters not dropping) → grants alternate UI, sweep, UI, … with strobes exactly 4 cycles apart (`HOLDOFF`=2).
- **Reject (`PARAM_CHECK_EN`):** min=0x800, max=0x400 → `nak_ui` one cycle, no load strobe, `par_out` unchanged. Repeat with duty=101 → nak. Duty=100 → ack.
- **Without `PARAM_CHECK_EN`:** same min>max bundle → ack plus load strobe, nak stays 0.
- **Hold window:** request arriving 1 cycle after a grant, and dropped before IDLE is re-entered → no grant, no ack.
- **Reset during COMMIT:** `reset` high the cycle strobes are active → at the next edge all outputs are 0 and state is IDLE. The first tie afterwards goes to UI.
